// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - LC-3 memory port sequencer: CPU/loader arbitration, SRAM timing, one MMIO address
module mem_bus_ctrl #(
  parameter int          MEM_LATENCY = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_wdata_i,
  output logic [15:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  input  logic        ldr_req_i,
  input  logic        ldr_we_i,
  input  logic [15:0] ldr_addr_i,
  input  logic [15:0] ldr_wdata_i,
  output logic [15:0] ldr_rdata_o,
  output logic        ldr_ack_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_data_o,
  output logic        busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;
  localparam logic [1:0] LAT_M1  = 2'(MEM_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d;   // 0 = CPU, 1 = loader; doubles as last_grant
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] ldr_rdata_q, ldr_rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        busy_q, busy_d;
  logic        is_io;

  assign is_io = (addr_q == IO_ADDR);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    hex_d       = hex_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_i || ldr_req_i) begin
          grant_d = (cpu_req_i && ldr_req_i) ? ~grant_q : ldr_req_i;
          we_d    = grant_d ? ldr_we_i    : cpu_we_i;
          addr_d  = grant_d ? ldr_addr_i  : cpu_addr_i;
          wdata_d = grant_d ? ldr_wdata_i : cpu_wdata_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (is_io) begin
          if (we_q)         hex_d       = wdata_q;
          else if (grant_q) ldr_rdata_d = sw_i;
          else              cpu_rdata_d = sw_i;
          state_d = S_ACK;
        end else if (we_q) begin
          state_d = S_ACK;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (grant_q) ldr_rdata_d = mem_rdata_i;
          else         cpu_rdata_d = mem_rdata_i;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 16'h0;
      wdata_q     <= 16'h0;
      cnt_q       <= 2'd0;
      cpu_rdata_q <= 16'h0;
      ldr_rdata_q <= 16'h0;
      hex_q       <= 16'h0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
      hex_q       <= hex_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en_o    = (state_q == S_ISSUE) && !is_io;
  assign mem_we_o    = (state_q == S_ISSUE) && !is_io && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_ack_o   = (state_q == S_ACK) && !grant_q;
  assign ldr_ack_o   = (state_q == S_ACK) && grant_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign ldr_rdata_o = ldr_rdata_q;
  assign hex_data_o  = hex_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl (latency 2 and latency 4 instances)
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cpu_req_i, cpu_we_i, ldr_req_i, ldr_we_i;
  logic [15:0] cpu_addr_i, cpu_wdata_i, ldr_addr_i, ldr_wdata_i, sw_i, mem_rdata_i;
  logic [15:0] cpu_rdata_o, ldr_rdata_o, mem_addr_o, mem_wdata_o, hex_data_o;
  logic        cpu_ack_o, ldr_ack_o, mem_en_o, mem_we_o, busy_o;

  logic        b_cpu_req_i, b_cpu_we_i, b_ldr_req_i, b_ldr_we_i;
  logic [15:0] b_cpu_addr_i, b_cpu_wdata_i, b_ldr_addr_i, b_ldr_wdata_i, b_sw_i, b_mem_rdata_i;
  logic [15:0] b_cpu_rdata_o, b_ldr_rdata_o, b_mem_addr_o, b_mem_wdata_o, b_hex_data_o;
  logic        b_cpu_ack_o, b_ldr_ack_o, b_mem_en_o, b_mem_we_o, b_busy_o;

  mem_bus_ctrl #(.MEM_LATENCY(2), .IO_ADDR(16'hFFFF)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o),
    .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i), .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
    .ldr_rdata_o(ldr_rdata_o), .ldr_ack_o(ldr_ack_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .sw_i(sw_i), .hex_data_o(hex_data_o), .busy_o(busy_o)
  );

  mem_bus_ctrl #(.MEM_LATENCY(4), .IO_ADDR(16'hFFFF)) u_dut4 (
    .clk(clk), .reset(reset),
    .cpu_req_i(b_cpu_req_i), .cpu_we_i(b_cpu_we_i), .cpu_addr_i(b_cpu_addr_i), .cpu_wdata_i(b_cpu_wdata_i),
    .cpu_rdata_o(b_cpu_rdata_o), .cpu_ack_o(b_cpu_ack_o),
    .ldr_req_i(b_ldr_req_i), .ldr_we_i(b_ldr_we_i), .ldr_addr_i(b_ldr_addr_i), .ldr_wdata_i(b_ldr_wdata_i),
    .ldr_rdata_o(b_ldr_rdata_o), .ldr_ack_o(b_ldr_ack_o),
    .mem_en_o(b_mem_en_o), .mem_we_o(b_mem_we_o), .mem_addr_o(b_mem_addr_o), .mem_wdata_o(b_mem_wdata_o),
    .mem_rdata_i(b_mem_rdata_i), .sw_i(b_sw_i), .hex_data_o(b_hex_data_o), .busy_o(b_busy_o)
  );

  // SRAM models: read data is valid only in the exact cycle MEM_LATENCY after the strobe.
  logic [15:0] mem_a [0:255];
  logic [15:0] pd_a [0:1];
  logic [1:0]  pv_a = 2'b00;
  logic [3:0]  pv_b = 4'b0000;

  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) mem_a[mem_addr_o[7:0]] <= mem_wdata_o;
    pd_a[0] <= mem_a[mem_addr_o[7:0]];
    pd_a[1] <= pd_a[0];
    pv_a    <= {pv_a[0], mem_en_o && !mem_we_o};
    pv_b    <= {pv_b[2:0], b_mem_en_o && !b_mem_we_o};
  end
  assign mem_rdata_i   = pv_a[1] ? pd_a[1] : 16'hDEAD;
  assign b_mem_rdata_i = pv_b[3] ? 16'h5A5A : 16'hDEAD;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ldr;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    int          ack_cyc;
    int          en_cyc;
    logic [15:0] cpu_rd;
    logic [15:0] ldr_rd;
    logic [15:0] hex;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input int idx, input vec_t v);
    int          ack_c = -1;
    int          en_c  = -1;
    logic        wrong = 1'b0;
    logic        en_we = 1'b0;
    logic [15:0] en_addr = 16'h0;
    logic [15:0] en_wd   = 16'h0;
    @(posedge clk); #1;
    sw_i = v.sw;
    if (v.ldr) begin
      ldr_req_i = 1'b1; ldr_we_i = v.we; ldr_addr_i = v.addr; ldr_wdata_i = v.wdata;
    end else begin
      cpu_req_i = 1'b1; cpu_we_i = v.we; cpu_addr_i = v.addr; cpu_wdata_i = v.wdata;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_en_o && en_c < 0) begin
        en_c = c; en_we = mem_we_o; en_addr = mem_addr_o; en_wd = mem_wdata_o;
      end
      if (v.ldr ? cpu_ack_o : ldr_ack_o) wrong = 1'b1;
      if (v.ldr ? ldr_ack_o : cpu_ack_o) begin
        ack_c = c;
        break;
      end
    end
    cpu_req_i = 1'b0;
    ldr_req_i = 1'b0;
    check($sformatf("v%0d_ack_cycle", idx), ack_c, v.ack_cyc);
    check($sformatf("v%0d_en_cycle", idx), en_c, v.en_cyc);
    check($sformatf("v%0d_other_ack", idx), {31'b0, wrong}, 32'd0);
    check($sformatf("v%0d_cpu_rdata", idx), cpu_rdata_o, v.cpu_rd);
    check($sformatf("v%0d_ldr_rdata", idx), ldr_rdata_o, v.ldr_rd);
    check($sformatf("v%0d_hex", idx), hex_data_o, v.hex);
    if (v.en_cyc >= 0) begin
      check($sformatf("v%0d_mem_we", idx), {31'b0, en_we}, {31'b0, v.we});
      check($sformatf("v%0d_mem_addr", idx), en_addr, v.addr);
      if (v.we) check($sformatf("v%0d_mem_wdata", idx), en_wd, v.wdata);
    end
  endtask

  initial begin
    int          ack_port [8];
    int          ack_cyc  [8];
    int          n_acks;
    int          cpu_done;
    int          ldr_done;
    logic        both_ack;
    int          b_ack_c;
    int          b_en_c;
    logic [15:0] b_en_addr;
    logic        b_busy_seen;

    vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 2, 1,  16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 4, 1,  16'hBEEF, 16'h0000, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0003, 2, -1, 16'h0003, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h0003, 2, -1, 16'h0003, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 16'h0020, 16'hCAFE, 16'h0003, 2, 1,  16'h0003, 16'h0000, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0003, 4, 1,  16'h0003, 16'hCAFE, 16'h1234};
    vecs[6] = '{1'b0, 1'b1, 16'h0010, 16'h1111, 16'h0003, 2, 1,  16'h0003, 16'hCAFE, 16'h1234};
    vecs[7] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0003, 4, 1,  16'h1111, 16'hCAFE, 16'h1234};
    vecs[8] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5C3, 2, -1, 16'h1111, 16'hA5C3, 16'h1234};

    reset = 1'b1;
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
    ldr_req_i = 0; ldr_we_i = 0; ldr_addr_i = 0; ldr_wdata_i = 0; sw_i = 0;
    b_cpu_req_i = 0; b_cpu_we_i = 0; b_cpu_addr_i = 0; b_cpu_wdata_i = 0;
    b_ldr_req_i = 0; b_ldr_we_i = 0; b_ldr_addr_i = 0; b_ldr_wdata_i = 0; b_sw_i = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", {busy_o, cpu_ack_o, ldr_ack_o, mem_en_o, mem_we_o}, 32'd0);
    check("rst_rdata", {cpu_rdata_o, ldr_rdata_o}, 32'd0);
    check("rst_mem_bus", {mem_addr_o, mem_wdata_o}, 32'd0);
    check("rst_hex", hex_data_o, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // reset while a CPU read sits in WAIT
    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    check("rw_issue_en", {31'b0, mem_en_o}, 32'd1);
    @(negedge clk);
    check("rw_wait_busy", {31'b0, busy_o}, 32'd1);
    reset = 1'b1; cpu_req_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rw_idle_busy", {31'b0, busy_o}, 32'd0);
    check("rw_strobes", {cpu_ack_o, ldr_ack_o, mem_en_o, mem_we_o}, 32'd0);
    check("rw_rdata", {cpu_rdata_o, ldr_rdata_o}, 32'd0);
    check("rw_hex", hex_data_o, 32'd0);
    check("rw_mem_bus", {mem_addr_o, mem_wdata_o}, 32'd0);
    both_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ack_o || ldr_ack_o || mem_en_o || busy_o) both_ack = 1'b1;
    end
    check("rw_no_late_activity", {31'b0, both_ack}, 32'd0);

    // both ports request in the same cycle after reset: CPU wins the first tie, then alternate
    for (int i = 0; i < 8; i++) begin ack_port[i] = -1; ack_cyc[i] = -1; end
    n_acks = 0; cpu_done = 0; ldr_done = 0; both_ack = 1'b0;
    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 16'h0040; cpu_wdata_i = 16'hC000;
    ldr_req_i = 1'b1; ldr_we_i = 1'b1; ldr_addr_i = 16'h0050; ldr_wdata_i = 16'hD000;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cpu_ack_o && ldr_ack_o) both_ack = 1'b1;
      if (cpu_ack_o && n_acks < 8) begin
        ack_port[n_acks] = 0; ack_cyc[n_acks] = c; n_acks++; cpu_done++;
        if (cpu_done == 4) cpu_req_i = 1'b0;
        else begin cpu_addr_i = 16'h0040 + 16'(cpu_done); cpu_wdata_i = 16'hC000 + 16'(cpu_done); end
      end
      if (ldr_ack_o && n_acks < 8) begin
        ack_port[n_acks] = 1; ack_cyc[n_acks] = c; n_acks++; ldr_done++;
        if (ldr_done == 4) ldr_req_i = 1'b0;
        else begin ldr_addr_i = 16'h0050 + 16'(ldr_done); ldr_wdata_i = 16'hD000 + 16'(ldr_done); end
      end
    end
    check("arb_ack_count", n_acks, 32'd8);
    check("arb_dual_ack", {31'b0, both_ack}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("arb%0d_port", i), ack_port[i], i % 2);
      check($sformatf("arb%0d_cycle", i), ack_cyc[i], 2 + 3 * i);
    end
    check("arb_cpu_last_word", mem_a[8'h43], 32'h0000C003);
    check("arb_ldr_last_word", mem_a[8'h53], 32'h0000D003);

    // latency-4 instance: loader read of SRAM
    b_ack_c = -1; b_en_c = -1; b_en_addr = 16'h0; b_busy_seen = 1'b0;
    @(posedge clk); #1;
    b_ldr_req_i = 1'b1; b_ldr_we_i = 1'b0; b_ldr_addr_i = 16'h3000;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (b_busy_o) b_busy_seen = 1'b1;
      if (b_mem_en_o && b_en_c < 0) begin b_en_c = c; b_en_addr = b_mem_addr_o; end
      if (b_cpu_ack_o) b_ack_c = 99;
      if (b_ldr_ack_o) begin b_ack_c = c; break; end
    end
    b_ldr_req_i = 1'b0;
    check("l4_ack_cycle", b_ack_c, 32'd6);
    check("l4_en_cycle", b_en_c, 32'd1);
    check("l4_mem_addr", b_en_addr, 32'h3000);
    check("l4_ldr_rdata", b_ldr_rdata_o, 32'h5A5A);
    check("l4_cpu_rdata", b_cpu_rdata_o, 32'h0);
    check("l4_busy_seen", {31'b0, b_busy_seen}, 32'd1);
    check("l4_hex_wdata", {b_hex_data_o, b_mem_wdata_o}, 32'd0);
    repeat (2) @(negedge clk);
    check("l4_idle_busy", {31'b0, b_busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
